// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table sequencer.
package truth_table_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tt_state_e;

    // Width of the settle counter; SETTLE must fit (0..15).
    localparam int SETTLE_W = 4;

    // Number of truth-table entries for an n-input function.
    function automatic int table_w(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Host/function-side bundle of the truth-table sequencer.
// slave: sequencer view; master: host + function-under-test view.
interface truth_table_sequencer_if #(
    parameter int N_IN = 3
);
    import truth_table_pkg::*;

    localparam int TW = table_w(N_IN);

    logic            start;
    logic [TW-1:0]   expected;
    logic [N_IN-1:0] fn_in;
    logic            fn_out;
    logic            busy;
    logic            done;
    logic [TW-1:0]   table_out;
    logic            pass;
    logic [N_IN-1:0] first_bad;
    logic [N_IN:0]   bad_count;

    modport slave (
        input  start, expected, fn_out,
        output fn_in, busy, done, table_out, pass, first_bad, bad_count
    );

    modport master (
        output start, expected, fn_out,
        input  fn_in, busy, done, table_out, pass, first_bad, bad_count
    );

endinterface

// File: rtl/tt_settle_timer.sv
// Per-vector settle timer: counts while enabled, expires when the count
// reaches SETTLE, then restarts from 0 on the same edge.
module tt_settle_timer
    import truth_table_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic expire
);

    logic [SETTLE_W-1:0] cnt;

    assign expire = (cnt == SETTLE_W'(SETTLE));

    // Count settle cycles; wrap to 0 on expiry so the next vector starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear || (en && expire))
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all 2^N_IN input vectors through a combinational function, captures
// its output into a truth table and compares against an expected mask.
// Optional feature macro: TT_SEQ_MISMATCH_LOG_EN (first_bad / bad_count).
module truth_table_sequencer
    import truth_table_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    truth_table_sequencer_if.slave    bus
);

    localparam int TW = table_w(N_IN);

    tt_state_e       state, state_nx;
    logic [N_IN:0]   idx;
    logic [TW-1:0]   exp_q;
    logic [TW-1:0]   table_q;
    logic [TW-1:0]   table_nx;
    logic            pass_q;
    logic            expire;
    logic            capture;
    logic            last;
    logic            accept;

    wire [N_IN-1:0] idx_lo = idx[N_IN-1:0];

    assign accept  = (state == IDLE) && bus.start;
    assign capture = (state == RUN) && expire;
    assign last    = (idx == (N_IN+1)'(TW-1));

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .en     (state == RUN),
        .clear  (state != RUN),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state: IDLE -> RUN on start, RUN -> DONE after last capture, DONE lasts one cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (capture && last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Table with the bit being captured this edge merged in, so pass sees it.
    always_comb begin
        table_nx         = table_q;
        table_nx[idx_lo] = bus.fn_out;
    end

    // Sweep datapath: latch expected on accept, capture one bit per vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q   <= '0;
            idx     <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
        end else if (accept) begin
            exp_q   <= bus.expected;
            idx     <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
        end else if (capture) begin
            table_q <= table_nx;
            if (last)
                pass_q <= (table_nx == exp_q);
            else
                idx <= idx + 1'b1;
        end
    end

`ifdef TT_SEQ_MISMATCH_LOG_EN
    logic [N_IN-1:0] first_bad_q;
    logic [N_IN:0]   bad_count_q;
    logic            miss;

    assign miss = (bus.fn_out != exp_q[idx_lo]);

    // Mismatch log: count differing captures, remember the lowest index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_bad_q <= '0;
            bad_count_q <= '0;
        end else if (accept) begin
            first_bad_q <= '0;
            bad_count_q <= '0;
        end else if (capture && miss) begin
            bad_count_q <= bad_count_q + 1'b1;
            if (bad_count_q == '0)
                first_bad_q <= idx_lo;
        end
    end

    assign bus.first_bad = first_bad_q;
    assign bus.bad_count = bad_count_q;
`else
    assign bus.first_bad = '0;
    assign bus.bad_count = '0;
`endif

    assign bus.fn_in     = (state == RUN) ? idx_lo : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.table_out = table_q;
    assign bus.pass      = pass_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: default build (SETTLE=2) plus a
// SETTLE=0 instance. Mismatch-log expectations follow TT_SEQ_MISMATCH_LOG_EN.
module tb_truth_table_sequencer;

`ifdef TT_SEQ_MISMATCH_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic mode_a = 1'b0;   // 0: F=A&B, 1: F=A^B^C
    logic mode_b = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    truth_table_sequencer_if #(.N_IN(3)) ifa ();
    truth_table_sequencer_if #(.N_IN(3)) ifb ();

    // Function under test, A is fn_in MSB.
    assign ifa.fn_out = mode_a ? ^ifa.fn_in : (ifa.fn_in[2] & ifa.fn_in[1]);
    assign ifb.fn_out = mode_b ? ^ifb.fn_in : (ifb.fn_in[2] & ifb.fn_in[1]);

    truth_table_sequencer #(.N_IN(3), .SETTLE(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    truth_table_sequencer #(.N_IN(3), .SETTLE(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One sweep on dut_a (SETTLE=2): returns the done edge and fn_in/busy errors.
    task automatic sweep_a(input logic [7:0] exp, output int done_edge, output int step_err);
        @(negedge clk);
        ifa.expected = exp;
        ifa.start    = 1'b1;
        @(posedge clk); #1;            // edge 0: accept
        ifa.start = 1'b0;
        done_edge = -1;
        step_err  = 0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (ifa.done) begin
                done_edge = e;
                break;
            end
            if (ifa.fn_in !== 3'(e / 3)) step_err++;
            if (ifa.busy !== 1'b1) step_err++;
        end
        @(posedge clk); #1;            // leave DONE
        chk("done_width", {31'd0, ifa.done}, 32'd0);
        chk("busy_after", {31'd0, ifa.busy}, 32'd0);
    endtask

    initial begin
        int de, se, dcnt, d1, d2;

        reset        = 1'b1;
        ifa.start    = 1'b0;
        ifa.expected = '0;
        ifb.start    = 1'b0;
        ifb.expected = '0;
        #12;
        chk("rst_busy",  {31'd0, ifa.busy}, 32'd0);
        chk("rst_done",  {31'd0, ifa.done}, 32'd0);
        chk("rst_fn_in", {29'd0, ifa.fn_in}, 32'd0);
        chk("rst_table", {24'd0, ifa.table_out}, 32'd0);
        chk("rst_pass",  {31'd0, ifa.pass}, 32'd0);
        chk("rst_fbad",  {29'd0, ifa.first_bad}, 32'd0);
        chk("rst_bcnt",  {28'd0, ifa.bad_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // AND, matching expectation
        mode_a = 1'b0;
        sweep_a(8'hC0, de, se);
        chk("and_done_edge", de, 24);
        chk("and_fn_steps",  se, 0);
        chk("and_table", {24'd0, ifa.table_out}, 32'hC0);
        chk("and_pass",  {31'd0, ifa.pass}, 32'd1);
        chk("and_bcnt",  {28'd0, ifa.bad_count}, 32'd0);

        // AND vs 8'hC1: single miss at index 0
        sweep_a(8'hC1, de, se);
        chk("andx_done_edge", de, 24);
        chk("andx_pass", {31'd0, ifa.pass}, 32'd0);
        chk("andx_fbad", {29'd0, ifa.first_bad}, 32'd0);
        chk("andx_bcnt", {28'd0, ifa.bad_count}, LOG ? 32'd1 : 32'd0);

        // AND vs 8'h48: misses at 3 and 7
        sweep_a(8'h48, de, se);
        chk("and48_pass", {31'd0, ifa.pass}, 32'd0);
        chk("and48_fbad", {29'd0, ifa.first_bad}, LOG ? 32'd3 : 32'd0);
        chk("and48_bcnt", {28'd0, ifa.bad_count}, LOG ? 32'd2 : 32'd0);

        // XOR3 vs inverted mask: every entry differs
        mode_a = 1'b1;
        sweep_a(8'h69, de, se);
        chk("xor_done_edge", de, 24);
        chk("xor_table", {24'd0, ifa.table_out}, 32'h96);
        chk("xor_pass",  {31'd0, ifa.pass}, 32'd0);
        chk("xor_fbad",  {29'd0, ifa.first_bad}, 32'd0);
        chk("xor_bcnt",  {28'd0, ifa.bad_count}, LOG ? 32'd8 : 32'd0);

        // start held high: done at 24, restart at 26, second done at 50
        mode_a = 1'b0;
        @(negedge clk);
        ifa.expected = 8'hC0;
        ifa.start    = 1'b1;
        @(posedge clk); #1;
        dcnt = 0; d1 = -1; d2 = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (ifa.done) begin
                dcnt++;
                if (dcnt == 1) d1 = e;
                if (dcnt == 2) begin
                    d2 = e;
                    ifa.start = 1'b0;
                end
            end
        end
        ifa.start = 1'b0;
        chk("hold_done_cnt", dcnt, 2);
        chk("hold_done1", d1, 24);
        chk("hold_done2", d2, 50);
        chk("hold_pass", {31'd0, ifa.pass}, 32'd1);

        // reset mid-sweep (XOR3): aborts with no done pulse
        mode_a = 1'b1;
        @(negedge clk);
        ifa.expected = 8'h96;
        ifa.start    = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_table", {24'd0, ifa.table_out}, 32'h06);
        chk("pre_rst_busy",  {31'd0, ifa.busy}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy",  {31'd0, ifa.busy}, 32'd0);
        chk("mid_rst_fn_in", {29'd0, ifa.fn_in}, 32'd0);
        chk("mid_rst_table", {24'd0, ifa.table_out}, 32'd0);
        chk("mid_rst_done",  {31'd0, ifa.done}, 32'd0);
        dcnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ifa.done) dcnt++;
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        if (ifa.done) dcnt++;
        chk("rst_no_done", dcnt, 0);
        mode_a = 1'b0;
        sweep_a(8'hC0, de, se);
        chk("post_rst_done_edge", de, 24);
        chk("post_rst_table", {24'd0, ifa.table_out}, 32'hC0);
        chk("post_rst_pass",  {31'd0, ifa.pass}, 32'd1);

        // SETTLE=0 instance: one cycle per vector
        mode_b = 1'b1;
        @(negedge clk);
        ifb.expected = 8'h96;
        ifb.start    = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b0;
        de = -1; se = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (ifb.done) begin
                de = e;
                break;
            end
            if (ifb.fn_in !== 3'(e)) se++;
        end
        chk("s0_done_edge", de, 8);
        chk("s0_fn_steps",  se, 0);
        chk("s0_table", {24'd0, ifb.table_out}, 32'h96);
        chk("s0_pass",  {31'd0, ifb.pass}, 32'd1);
        @(posedge clk); #1;
        chk("s0_idle", {31'd0, ifb.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Sequencing controller for a combinational N-input, 1-output logic function under test (e.g. a 3-input `top(A,B,C,F)` block). On `start` it sweeps every input combination through the function in binary order and holds each one for a programmable settle time. It captures the output into a 2^N-bit truth-table vector, then compares that vector against an expected minterm mask. It sits between a host/test controller and the function block and replaces hand-written per-vector stimulus.

## Interface
Parameters:
- `N_IN`, default 3: number of function inputs; the table is 2^N_IN bits.
- `SETTLE`, default 2: wait cycles per vector before sampling; legal range is 0..15.

Ports:
- `clk`, input, 1: the single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begins a sweep; accepted only in IDLE.
- `expected`, input, 2^N_IN: expected table; bit i is F for input i. Latched when `start` is accepted.
- `fn_in`, output, N_IN: drives the function inputs; MSB is the first input (A).
- `fn_out`, input, 1: the function output F.
- `busy`, output, 1: high from the cycle after start acceptance until DONE is exited.
- `done`, output, 1: one-cycle pulse at the end of the sweep.
- `table_out`, output, 2^N_IN: captured truth table; holds its value until the next accepted start.
- `pass`, output, 1: `table_out == expected_latched`; valid while `done` is high and held afterwards.
- `first_bad`, output, N_IN: lowest mismatching index (see Configuration).
- `bad_count`, output, N_IN+1: number of mismatching entries (see Configuration).

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `fn_in`=0 and `busy`=0.
  - When `start`=1: latch `expected`, set idx=0 and cnt=0, clear `table_out`, `pass`, `first_bad` and `bad_count`, then go to RUN.
- RUN:
  - `fn_in`=idx.
  - If cnt<SETTLE: cnt++.
  - Otherwise: `table_out[idx]` <= `fn_out` and cnt <= 0.
    - If idx is 2^N_IN−1, go to DONE with `pass` computed from the final table, including the bit captured on this edge.
    - Otherwise idx++.
- DONE:
  - `done`=1 for exactly one cycle, then go to IDLE.
  - `fn_in` returns to 0 on entering DONE.
- `start` while in RUN or DONE is ignored; it is not queued.
- idx is an N_IN+1-bit counter internally, so there is no wrap-around ambiguity at 2^N_IN−1.
- Reset values: state=IDLE; `fn_in`, `busy`, `done`, `table_out`, `pass`, `first_bad`, `bad_count` and the latched expected value are all 0.
- Reset asserted mid-sweep aborts immediately and asynchronously to the reset values, with no `done` pulse.

## Timing
- Each vector occupies SETTLE+1 cycles with `fn_in` stable.
- `fn_out` is sampled on the last edge of each vector; it must settle within SETTLE+1 cycles.
- Index i is captured on edge (i+1)·(SETTLE+1) counted after the start-accept edge.
- `done`/`pass` are visible in the cycle following edge 2^N_IN·(SETTLE+1). With the defaults that is edge 24.
- `busy` falls in the same edge that leaves DONE. A new `start` is accepted on the next edge at the earliest.

## Configuration
- `TT_SEQ_MISMATCH_LOG_EN` defined:
  - On each capture whose bit differs from the latched expected bit, `bad_count` increments.
  - On the first such mismatch, `first_bad` <= idx.
  - Both are final when `done` is high.
- `TT_SEQ_MISMATCH_LOG_EN` undefined:
  - The mismatch logic is not built.
  - `first_bad` and `bad_count` are tied to 0; the ports remain for interface stability.
  - `pass` is unaffected.

## Structure
- Package `truth_table_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - the `SETTLE_W` constant (4);
  - a `table_w(n)` function returning 2^n.
- Sub-module `tt_settle_timer` (cnt register, `SETTLE` compare, `expire` output, `clear` input) is instantiated once in RUN.
- The rest of the design is a single FSM module.

## Test plan
- F=A&B (expected 8'b1100_0000), SETTLE=2, one start pulse:
  - `done` at edge 24, `table_out`=8'hC0, `pass`=1.
  - `fn_in` steps 0..7, each held for 3 cycles.
- Same function with `expected`=8'b1100_0001:
  - `pass`=0.
  - With `TT_SEQ_MISMATCH_LOG_EN`: `first_bad`=0, `bad_count`=1.
- XOR3 function (8'h96) with `expected`=8'h69:
  - `pass`=0.
  - With `TT_SEQ_MISMATCH_LOG_EN`: `bad_count`=8, `first_bad`=0.
- `start` held high for the whole sweep:
  - exactly one `done` pulse;
  - restart accepted on the first edge after returning to IDLE, producing a second `done` 24 edges later.
- `reset` asserted at edge 10 of a sweep:
  - all outputs 0 immediately, with no `done` pulse;
  - after release, a fresh start completes with `table_out`=8'hC0.
- SETTLE=0 build:
  - one cycle per vector, `done` at edge 8, `table_out` correct.
